lcd_editor: RTL
===============

LCD_EDITOR -- requirements
Module: lcd_editor

Interface
REQ-001 Parameters (name, default, meaning):
  COLS 16 columns per row (1..40)
  ROWS 2 rows (1..4)
  NUM_KEYS 10 digit buttons; key i maps to ASCII '0'+((i+1)%10) with MSB = key 1
  PWR_CNT 70 power-up wait, in cycles
  CMD_CNT 30 last count of a standard command slot
  CLR_CNT 100 last count of the clear-display slot
  E_POS 20 count at which LCD_E pulses; must satisfy E_POS < CMD_CNT
REQ-002 Ports (name, direction, width, meaning):
  clk in 1 clock
  rst in 1 synchronous reset, active-high
  number_btn in NUM_KEYS digit buttons, level
  control_btn in 4 [3]=left [2]=right [1]=backspace [0]=clear, level
  line_sel in 2 requested row for the cursor jump
  LCD_E out 1 enable strobe
  LCD_RS out 1 register select
  LCD_RW out 1 read/write; always 0
  LCD_DATA out 8 command or character byte
  cursor_row out 2 current row
  cursor_col out 6 current column
  busy out 1 high in every state except IDLE

Function
REQ-003 Button inputs are rising-edge detected with one register stage; each edge is a one-cycle event.
REQ-004 States: PWR_WAIT, FUNC_SET (0x38), DISP_ON (0x0F), ENTRY (0x06), CLEAR (0x01), IDLE, SET_ADDR, WRITE_CH, BS_SPACE.
REQ-005 Init sequence: PWR_WAIT (PWR_CNT+1 cycles) -> FUNC_SET -> DISP_ON -> ENTRY -> CLEAR -> SET_ADDR -> IDLE.
REQ-006 Slot timing:
  - Each command slot lasts CMD_CNT+1 cycles; the CLEAR slot lasts CLR_CNT+1 cycles.
  - RS and DATA are held for the whole slot.
  - LCD_E is high for exactly one cycle, at cnt==E_POS.
  - cnt resets to 0 on every state entry.
REQ-007 In IDLE, events are accepted with priority digit > control (clear > backspace > left > right) > line_sel change.
  - Events that arrive while busy are dropped.
  - If several digit edges occur together, the lowest index wins.
REQ-008 Digit event:
  - WRITE_CH drives RS=1 with the ASCII byte.
  - Then col+1. At col==COLS-1: col=0, row=(row+1)%ROWS, followed by a SET_ADDR slot.
  - Otherwise return directly to IDLE.
REQ-009 Left/right event: move the cursor with wrap across rows (row0 col0 left -> row ROWS-1 col COLS-1, and the mirror case for right), then SET_ADDR -> IDLE.
REQ-010 Backspace event: move left as in REQ-009, then SET_ADDR -> BS_SPACE (writes 0x20) -> SET_ADDR -> IDLE. Net effect: the cursor sits on the blanked cell.
REQ-011 Clear event: CLEAR -> SET_ADDR with row=0, col=0 -> IDLE.
REQ-012 line_sel change (compared against a registered copy):
  - row = line_sel % ROWS, col = 0, then SET_ADDR.
  - A value >= ROWS is reduced modulo ROWS.
REQ-013 SET_ADDR data = 0x80 | base(row) + col, with base = {0x00, 0x40, 0x14, 0x54}. Arithmetic is 8-bit.
REQ-014 cursor_row and cursor_col update on the cycle the event is accepted. They are never out of range.

Reset
REQ-015 While rst is high, and on the cycle after it is released:
  - state=PWR_WAIT, cnt=0, LCD_E=0, LCD_RS=0, LCD_RW=0, LCD_DATA=0x00
  - cursor 0/0, busy=1, edge registers and the line_sel copy cleared
REQ-016 Asserting reset mid-slot aborts the slot immediately; no LCD_E pulse may occur after reset is sampled.

Structure
REQ-017 Package lcd_pkg holds:
  - the state enum
  - command constants 0x38/0x0F/0x06/0x01/0x80/0x20
  - the row-base table
  - a function mapping (row, col) to the DDRAM address
REQ-018 One sub-module, lcd_btn_edge (parametrised width), performs the edge detection; all other logic stays in lcd_editor.

Verification
REQ-019 Reset release -> exactly 5 LCD_E pulses with DATA 0x38, 0x0F, 0x06, 0x01, 0x80, in that order; busy falls afterwards.
REQ-020 Press key 0 (MSB) at row0 col15 -> write 0x31, then 0xC0; cursor ends at 1/0.
REQ-021 Right at row1 col15 (ROWS=2) -> 0x80, cursor 0/0; Left at 0/0 -> 0xCF.
REQ-022 Backspace at 0/3 -> 0x82, RS=1 0x20, 0x82; cursor ends at 0/2.
REQ-023 Digit and clear in the same IDLE cycle -> only the digit is written; a clear pressed during busy produces no pulse.
REQ-024 Reset asserted at cnt==E_POS-1 of WRITE_CH -> no LCD_E pulse; the init sequence restarts.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared types and constants for the HD44780-style character LCD editor.
// Holds the controller state encoding, command bytes and DDRAM address helper.
package lcd_pkg;

    typedef enum logic [3:0] {
        PWR_WAIT,
        FUNC_SET,
        DISP_ON,
        ENTRY,
        CLEAR,
        IDLE,
        SET_ADDR,
        WRITE_CH,
        BS_SPACE
    } lcd_state_t;

    localparam logic [7:0] CMD_FUNC_SET = 8'h38;
    localparam logic [7:0] CMD_DISP_ON  = 8'h0F;
    localparam logic [7:0] CMD_ENTRY    = 8'h06;
    localparam logic [7:0] CMD_CLEAR    = 8'h01;
    localparam logic [7:0] CMD_SET_ADDR = 8'h80;
    localparam logic [7:0] CHR_SPACE    = 8'h20;

    // DDRAM start address of each display row, indexed by row number
    localparam logic [3:0][7:0] ROW_BASE = {8'h54, 8'h14, 8'h40, 8'h00};

    function automatic logic [7:0] ddram_addr(input logic [1:0] row, input logic [5:0] col);
        return CMD_SET_ADDR | (ROW_BASE[row] + {2'b00, col});
    endfunction

endpackage

// File: rtl/lcd_if.sv
// Parallel bus towards the character LCD module.
interface lcd_if;

    logic       LCD_E;
    logic       LCD_RS;
    logic       LCD_RW;
    logic [7:0] LCD_DATA;

    modport master (output LCD_E, output LCD_RS, output LCD_RW, output LCD_DATA);
    modport slave  (input  LCD_E, input  LCD_RS, input  LCD_RW, input  LCD_DATA);

endinterface

// File: rtl/lcd_btn_edge.sv
// Rising-edge detector for level button inputs; each press yields a one-cycle pulse.
module lcd_btn_edge #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] level,
    output logic [WIDTH-1:0] rise
);

    logic [WIDTH-1:0] prev;

    always_ff @(posedge clk) begin
        if (rst) prev <= '0;
        else     prev <= level;
    end

    assign rise = level & ~prev;

endmodule

// File: rtl/lcd_editor.sv
// Text editor front-end for a character LCD: initialises the panel, then turns
// digit/cursor/backspace/clear/line buttons into timed LCD command slots.
module lcd_editor
    import lcd_pkg::*;
#(
    parameter int unsigned COLS     = 16,
    parameter int unsigned ROWS     = 2,
    parameter int unsigned NUM_KEYS = 10,
    parameter int unsigned PWR_CNT  = 70,
    parameter int unsigned CMD_CNT  = 30,
    parameter int unsigned CLR_CNT  = 100,
    parameter int unsigned E_POS    = 20
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_KEYS-1:0] number_btn,
    input  logic [3:0]          control_btn,
    input  logic [1:0]          line_sel,
    lcd_if.master               lcd,
    output logic [1:0]          cursor_row,
    output logic [5:0]          cursor_col,
    output logic                busy
);

    lcd_state_t    state, state_n;
    logic [15:0]   cnt, slot_last;
    logic [1:0]    row, row_n, line_q;
    logic [5:0]    col, col_n;
    logic [7:0]    ch, ch_n, key_ch, data;
    logic          wrap_pend, wrap_n, bs_pend, bs_n;
    logic          key_hit, rs, e;
    logic [NUM_KEYS-1:0] key_rise;
    logic [3:0]    ctl_rise;
    logic [1:0]    row_inc, row_dec, left_row, right_row, line_row;
    logic [5:0]    left_col, right_col;

    lcd_btn_edge #(.WIDTH(NUM_KEYS)) u_key_edge (
        .clk(clk), .rst(rst), .level(number_btn), .rise(key_rise)
    );

    lcd_btn_edge #(.WIDTH(4)) u_ctl_edge (
        .clk(clk), .rst(rst), .level(control_btn), .rise(ctl_rise)
    );

    // Lowest key index sits in the MSB, so scan from the top bit down
    always_comb begin
        key_hit = 1'b0;
        key_ch  = '0;
        for (int unsigned i = 0; i < NUM_KEYS; i++) begin
            if (!key_hit && key_rise[NUM_KEYS-1-i]) begin
                key_hit = 1'b1;
                key_ch  = 8'h30 + 8'((i + 1) % 10);
            end
        end
    end

    always_comb begin
        row_inc   = (row == 2'(ROWS - 1)) ? '0 : row + 2'd1;
        row_dec   = (row == '0) ? 2'(ROWS - 1) : row - 2'd1;
        left_row  = (col == '0) ? row_dec : row;
        left_col  = (col == '0) ? 6'(COLS - 1) : col - 6'd1;
        right_row = (col == 6'(COLS - 1)) ? row_inc : row;
        right_col = (col == 6'(COLS - 1)) ? '0 : col + 6'd1;
        line_row  = 2'({30'd0, line_sel} % ROWS);
    end

    always_comb begin
        case (state)
            PWR_WAIT: slot_last = 16'(PWR_CNT);
            CLEAR:    slot_last = 16'(CLR_CNT);
            default:  slot_last = 16'(CMD_CNT);
        endcase
    end

    always_comb begin
        state_n = state;
        row_n   = row;
        col_n   = col;
        ch_n    = ch;
        wrap_n  = wrap_pend;
        bs_n    = bs_pend;
        case (state)
            PWR_WAIT: if (cnt == slot_last) state_n = FUNC_SET;
            FUNC_SET: if (cnt == slot_last) state_n = DISP_ON;
            DISP_ON:  if (cnt == slot_last) state_n = ENTRY;
            ENTRY:    if (cnt == slot_last) state_n = CLEAR;
            CLEAR:    if (cnt == slot_last) state_n = SET_ADDR;
            SET_ADDR: if (cnt == slot_last) begin
                state_n = bs_pend ? BS_SPACE : IDLE;
                bs_n    = 1'b0;
            end
            BS_SPACE: if (cnt == slot_last) state_n = SET_ADDR;
            WRITE_CH: if (cnt == slot_last) begin
                state_n = wrap_pend ? SET_ADDR : IDLE;
                wrap_n  = 1'b0;
            end
            IDLE: begin
                if (key_hit) begin
                    state_n = WRITE_CH;
                    ch_n    = key_ch;
                    row_n   = right_row;
                    col_n   = right_col;
                    wrap_n  = (col == 6'(COLS - 1));
                end else if (ctl_rise[0]) begin
                    state_n = CLEAR;
                    row_n   = '0;
                    col_n   = '0;
                end else if (ctl_rise[1]) begin
                    state_n = SET_ADDR;
                    row_n   = left_row;
                    col_n   = left_col;
                    bs_n    = 1'b1;
                end else if (ctl_rise[3]) begin
                    state_n = SET_ADDR;
                    row_n   = left_row;
                    col_n   = left_col;
                end else if (ctl_rise[2]) begin
                    state_n = SET_ADDR;
                    row_n   = right_row;
                    col_n   = right_col;
                end else if (line_sel != line_q) begin
                    state_n = SET_ADDR;
                    row_n   = line_row;
                    col_n   = '0;
                end
            end
            default: state_n = PWR_WAIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= PWR_WAIT;
            cnt       <= '0;
            row       <= '0;
            col       <= '0;
            ch        <= '0;
            wrap_pend <= 1'b0;
            bs_pend   <= 1'b0;
            line_q    <= '0;
        end else begin
            state     <= state_n;
            cnt       <= (state_n != state || state == IDLE) ? '0 : cnt + 16'd1;
            row       <= row_n;
            col       <= col_n;
            ch        <= ch_n;
            wrap_pend <= wrap_n;
            bs_pend   <= bs_n;
            line_q    <= line_sel;
        end
    end

    always_comb begin
        rs   = 1'b0;
        data = '0;
        case (state)
            FUNC_SET: data = CMD_FUNC_SET;
            DISP_ON:  data = CMD_DISP_ON;
            ENTRY:    data = CMD_ENTRY;
            CLEAR:    data = CMD_CLEAR;
            SET_ADDR: data = ddram_addr(row, col);
            WRITE_CH: begin rs = 1'b1; data = ch; end
            BS_SPACE: begin rs = 1'b1; data = CHR_SPACE; end
            default: ;
        endcase
        e = (state != PWR_WAIT) && (state != IDLE) && (cnt == 16'(E_POS));
    end

    assign lcd.LCD_E    = e;
    assign lcd.LCD_RS   = rs;
    assign lcd.LCD_RW   = 1'b0;
    assign lcd.LCD_DATA = data;
    assign cursor_row   = row;
    assign cursor_col   = col;
    assign busy         = (state != IDLE);

endmodule
